main_fsm_controller: RTL and testbench

- Moore-style control FSM that sequences a shared single-ALU, single-memory RV32I multicycle datapath.
- Issues the per-cycle ALUOp (00 add, 01 subtract, 10 funct-decoded) consumed by the ALU decoder, plus mux selects and write enables for PC, IR, register file and memory.
- Sits beside the ALU decoder inside the top-level control unit; the instruction register feeds `op`, and the ALU feeds `Zero`.

---
 rtl/main_fsm_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_main_fsm_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_fsm_controller.sv
// rtl/main_fsm_controller.sv - Moore control FSM for a multicycle RV32I datapath
//
// Purpose:
//   Sequences a shared single-ALU, single-memory RV32I multicycle datapath.
//   It drives the per-cycle ALUOp for the ALU decoder, the mux selects, and the
//   write enables for PC, IR, register file and memory.
//
// Configuration macro:
//   ILLEGAL_TRAP_EN
//     Defined:   an unknown opcode parks the FSM in TRAP until rst, with illegal = 1.
//     Undefined: an unknown opcode returns to FETCH, giving a 2-cycle NOP.
//                In this build illegal is tied to 0.
//
// Ports:
//   clk        in   1  sole clock, rising edge
//   rst        in   1  synchronous active-high reset
//   op         in   7  opcode from the instruction register
//   Zero       in   1  ALU zero flag, used only in BEQ
//   PCWrite    out  1  PC load enable
//   AdrSrc     out  1  memory address select (0 PC, 1 Result)
//   MemWrite   out  1  memory write enable
//   IRWrite    out  1  IR / OldPC load enable
//   ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
//   ALUOp      out  2  00 add, 01 sub, 10 funct-decoded
//   ALUSrcA    out  2  00 PC, 01 OldPC, 10 RD1
//   ALUSrcB    out  2  00 RD2, 01 ImmExt, 10 constant 4
//   ImmSrc     out  2  00 I, 01 S, 10 B, 11 J
//   RegWrite   out  1  register file write enable
//   instr_done out  1  pulse in the final state of each instruction
//   illegal    out  1  illegal-opcode flag
//   state      out  4  current state, for debug

module main_fsm_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t r_state;
  state_t w_next;

  logic w_pc_update;
  logic w_branch;
  logic w_trap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      // Only the load/store split is re-read after DECODE.
      S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = S_FETCH;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`else
      S_TRAP:     w_next = S_FETCH;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_trap      = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    instr_done  = 1'b0;
    ResultSrc   = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    case (r_state)
      S_FETCH: begin
        IRWrite     = 1'b1;
        w_pc_update = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        w_branch   = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP: begin
        w_trap = 1'b1;
      end
      default: begin
      end
    endcase

    PCWrite = w_pc_update | (w_branch & Zero);

    // During reset, present FETCH selects with every enable held low so that
    // an abandoned instruction can never write anything in the reset cycle.
    if (rst) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      w_trap     = 1'b0;
      ResultSrc  = 2'b10;
      ALUOp      = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b10;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = w_trap;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_main_fsm_controller.sv
// tb/tb_main_fsm_controller.sv - directed bench for main_fsm_controller
module tb_main_fsm_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  main_fsm_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUOp      (ALUOp),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Enables packed as {PCWrite, IRWrite, RegWrite, MemWrite, instr_done, illegal}
  function automatic logic [7:0] en();
    return {2'b00, PCWrite, IRWrite, RegWrite, MemWrite, instr_done, illegal};
  endfunction

  initial begin
    rst  = 1'b1;
    op   = 7'b0000011;
    Zero = 1'b0;
    tick();
    tick();
    chk("rst_state", {4'd0, state}, 8'd0);
    chk("rst_enables", en(), 8'h00);
    chk("rst_srcb", {6'd0, ALUSrcB}, 8'd2);
    chk("rst_result", {6'd0, ResultSrc}, 8'd2);
    chk("rst_srca", {6'd0, ALUSrcA}, 8'd0);

    // lw: 0,1,2,3,4,0
    rst = 1'b0;
    #1;
    chk("lw_fetch_en", en(), 8'h30);
    chk("lw_fetch_srcb", {6'd0, ALUSrcB}, 8'd2);
    tick();
    chk("lw_decode_state", {4'd0, state}, 8'd1);
    chk("lw_decode_srcs", {4'd0, ALUSrcA, ALUSrcB}, 8'h05);
    chk("lw_imm", {6'd0, ImmSrc}, 8'd0);
    chk("lw_decode_en", en(), 8'h00);
    tick();
    chk("lw_memadr_state", {4'd0, state}, 8'd2);
    chk("lw_memadr_srcs", {4'd0, ALUSrcA, ALUSrcB}, 8'h09);
    tick();
    chk("lw_memread_state", {4'd0, state}, 8'd3);
    chk("lw_memread_adr", {7'd0, AdrSrc}, 8'd1);
    chk("lw_memread_en", en(), 8'h00);
    tick();
    chk("lw_memwb_state", {4'd0, state}, 8'd4);
    chk("lw_memwb_en", en(), 8'h0A);
    chk("lw_memwb_result", {6'd0, ResultSrc}, 8'd1);
    tick();
    chk("lw_back_fetch", {4'd0, state}, 8'd0);

    // sw: 0,1,2,5,0
    op = 7'b0100011;
    #1;
    chk("sw_imm", {6'd0, ImmSrc}, 8'd1);
    tick();
    tick();
    chk("sw_memadr_state", {4'd0, state}, 8'd2);
    tick();
    chk("sw_memwrite_state", {4'd0, state}, 8'd5);
    chk("sw_memwrite_en", en(), 8'h06);
    chk("sw_memwrite_adr", {7'd0, AdrSrc}, 8'd1);
    tick();
    chk("sw_back_fetch", {4'd0, state}, 8'd0);
    chk("sw_fetch_memwrite", {7'd0, MemWrite}, 8'd0);

    // beq taken: 0,1,10,0
    op = 7'b1100011;
    #1;
    chk("beq_imm", {6'd0, ImmSrc}, 8'd2);
    tick();
    Zero = 1'b1;
    #1;
    chk("beq_decode_zero_ignored", {7'd0, PCWrite}, 8'd0);
    tick();
    chk("beq_state", {4'd0, state}, 8'd10);
    chk("beq_aluop", {6'd0, ALUOp}, 8'd1);
    chk("beq_taken_en", en(), 8'h22);
    Zero = 1'b0;
    #1;
    chk("beq_zero_drop_pcwrite", {7'd0, PCWrite}, 8'd0);
    tick();
    chk("beq_taken_back_fetch", {4'd0, state}, 8'd0);

    // beq not taken
    tick();
    tick();
    chk("beq_nt_state", {4'd0, state}, 8'd10);
    chk("beq_nt_en", en(), 8'h02);
    tick();
    chk("beq_nt_back_fetch", {4'd0, state}, 8'd0);

    // R-type, op changes in EXECUTER must not redirect the path
    op = 7'b0110011;
    tick();
    tick();
    chk("r_state", {4'd0, state}, 8'd6);
    chk("r_aluop", {6'd0, ALUOp}, 8'd2);
    chk("r_srcs", {4'd0, ALUSrcA, ALUSrcB}, 8'h08);
    op = 7'b0000011;
    tick();
    chk("r_aluwb_state", {4'd0, state}, 8'd7);
    chk("r_aluwb_en", en(), 8'h0A);
    tick();
    chk("r_back_fetch", {4'd0, state}, 8'd0);

    // I-type ALU
    op = 7'b0010011;
    tick();
    tick();
    chk("i_state", {4'd0, state}, 8'd8);
    chk("i_aluop", {6'd0, ALUOp}, 8'd2);
    chk("i_srcs", {4'd0, ALUSrcA, ALUSrcB}, 8'h09);
    tick();
    chk("i_aluwb_state", {4'd0, state}, 8'd7);
    tick();
    chk("i_back_fetch", {4'd0, state}, 8'd0);

    // jal
    op = 7'b1101111;
    #1;
    chk("jal_imm", {6'd0, ImmSrc}, 8'd3);
    tick();
    tick();
    chk("jal_state", {4'd0, state}, 8'd9);
    chk("jal_en", en(), 8'h20);
    chk("jal_srcs", {4'd0, ALUSrcA, ALUSrcB}, 8'h06);
    chk("jal_aluop", {6'd0, ALUOp}, 8'd0);
    tick();
    chk("jal_aluwb_state", {4'd0, state}, 8'd7);
    tick();
    chk("jal_back_fetch", {4'd0, state}, 8'd0);

    // illegal opcode
    op = 7'b1111111;
    #1;
    chk("ill_imm", {6'd0, ImmSrc}, 8'd0);
    tick();
    chk("ill_decode_en", en(), 8'h00);
    tick();
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      chk("ill_trap_state", {4'd0, state}, 8'd11);
      chk("ill_trap_en", en(), 8'h01);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("ill_trap_rst_en", en(), 8'h00);
    tick();
    chk("ill_trap_rst_state", {4'd0, state}, 8'd0);
    rst = 1'b0;
    #1;
`else
    chk("ill_nop_state", {4'd0, state}, 8'd0);
    chk("ill_nop_illegal", {7'd0, illegal}, 8'd0);
`endif

    // reset in MEMREAD
    op = 7'b0000011;
    tick();
    tick();
    tick();
    chk("mr_state", {4'd0, state}, 8'd3);
    rst = 1'b1;
    #1;
    chk("mr_rst_en", en(), 8'h00);
    chk("mr_rst_adr", {7'd0, AdrSrc}, 8'd0);
    chk("mr_rst_srcb", {6'd0, ALUSrcB}, 8'd2);
    tick();
    chk("mr_after_rst_state", {4'd0, state}, 8'd0);
    chk("mr_after_rst_regwrite", {7'd0, RegWrite}, 8'd0);
    rst = 1'b0;
    #1;
    chk("mr_release_en", en(), 8'h30);
    chk("mr_release_result", {6'd0, ResultSrc}, 8'd2);
    tick();
    chk("mr_release_decode", {4'd0, state}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
